// File: rtl/ddr2_user_af_fifo.sv
// ddr2_user_af_fifo
// Single-clock command/address FIFO between the DDR2 application traffic
// generator and the controller's command sequencer. Entries are presented in
// first-word-fall-through form from a registered head, with a registered
// almost-full back-pressure flag and sticky overflow/underflow debug status.
module ddr2_user_af_fifo #(
  parameter int DEPTH     = 16,  // entries, power of two, 4..64
  parameter int AF_THRESH = 12   // almost-full occupancy threshold, 1..DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [35:0]              app_af_addr,
  input  logic                     app_af_wren,
  output logic                     af_almost_full,
  input  logic                     ctrl_af_rden,
  output logic                     af_empty,
  output logic [2:0]               af_cmd,
  output logic [31:0]              af_addr,
  output logic                     af_cmd_illegal,
  output logic [$clog2(DEPTH):0]   af_count,
  output logic                     af_overflow,
  output logic                     af_underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(AF_THRESH);
  localparam logic [2:0] CMD_WR = 3'b100;
  localparam logic [2:0] CMD_RD = 3'b101;

  // Bit 35 of the write word is reserved and never stored.
  logic unused_rsvd;
  assign unused_rsvd = app_af_addr[35];

  logic [34:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] rd_next;
  logic [CW-1:0] count_q, count_d;
  logic [34:0]   head_q, head_d;
  logic          empty_q, empty_d;
  logic          afull_q, afull_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          push_ok, pop_ok;

  // A pop needs a valid head; a push needs space, or a same-cycle pop that frees a slot.
  assign pop_ok  = ctrl_af_rden && !empty_q;
  assign push_ok = app_af_wren && ((count_q < DEPTH_C) || pop_ok);
  assign rd_next = rd_ptr_q + PW'(1);

  // Next-state for pointers, occupancy, head register and flags.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_next;

    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (pop_ok) begin
      // With one entry left, the successor (if any) is the word being written
      // this very cycle, so it must bypass the array.
      if (count_q == CW'(1)) begin
        if (push_ok) head_d = app_af_addr[34:0];
      end else begin
        head_d = mem[rd_next];
      end
    end else if (push_ok && empty_q) begin
      head_d = app_af_addr[34:0];
    end

    if (app_af_wren && !push_ok) ovf_d = 1'b1;
    if (ctrl_af_rden && empty_q) unf_d = 1'b1;

    empty_d = (count_d == '0);
    afull_d = (count_d >= THRESH_C);
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset; occupancy and pointers alone decide which entries are valid.
    if (push_ok) mem[wr_ptr_q] <= app_af_addr[34:0];
  end

  assign af_count       = count_q;
  assign af_empty       = empty_q;
  assign af_almost_full = afull_q;
  assign af_cmd         = head_q[34:32];
  assign af_addr        = head_q[31:0];
  assign af_overflow    = ovf_q;
  assign af_underflow   = unf_q;
  assign af_cmd_illegal = !empty_q && (head_q[34:32] != CMD_WR) && (head_q[34:32] != CMD_RD);

endmodule

// File: tb/tb_ddr2_user_af_fifo.sv
// tb_ddr2_user_af_fifo
// Scoreboard bench: the driver keeps a queue model of the FIFO contents and
// pushes expected words; a monitor pops and compares whenever the sequencer
// side accepts a head entry.
module tb_ddr2_user_af_fifo;

  localparam int DEPTH     = 16;
  localparam int AF_THRESH = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [35:0] app_af_addr = '0;
  logic        app_af_wren = 1'b0;
  logic        ctrl_af_rden = 1'b0;
  logic        af_almost_full, af_empty, af_cmd_illegal, af_overflow, af_underflow;
  logic [2:0]  af_cmd;
  logic [31:0] af_addr;
  logic [4:0]  af_count;

  int checks   = 0;
  int failures = 0;

  logic [34:0] sb_q [$];
  bit          m_ovf = 1'b0;
  bit          m_unf = 1'b0;

  ddr2_user_af_fifo #(.DEPTH(DEPTH), .AF_THRESH(AF_THRESH)) dut (
    .clk            (clk),
    .reset          (reset),
    .app_af_addr    (app_af_addr),
    .app_af_wren    (app_af_wren),
    .af_almost_full (af_almost_full),
    .ctrl_af_rden   (ctrl_af_rden),
    .af_empty       (af_empty),
    .af_cmd         (af_cmd),
    .af_addr        (af_addr),
    .af_cmd_illegal (af_cmd_illegal),
    .af_count       (af_count),
    .af_overflow    (af_overflow),
    .af_underflow   (af_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: inputs and outputs are stable at the falling edge; an accepted pop
  // must deliver the oldest word the model holds.
  always @(negedge clk) begin
    if (!reset && ctrl_af_rden && !af_empty) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected: got %0h expected no entry at %0t", {af_cmd, af_addr}, $time);
      end else begin
        logic [34:0] exp_w;
        exp_w = sb_q.pop_front();
        check("pop_data", {af_cmd, af_addr}, exp_w);
      end
    end
  end

  // Post-edge comparison of occupancy, flags and head against the model.
  task automatic verify(input bit was_reset);
    int n;
    bit legal;
    n = sb_q.size();
    check("count", af_count, n);
    check("empty", af_empty, n == 0);
    check("almost_full", af_almost_full, n >= AF_THRESH);
    check("overflow", af_overflow, m_ovf);
    check("underflow", af_underflow, m_unf);
    if (n > 0) begin
      legal = (sb_q[0][34:32] == 3'b100) || (sb_q[0][34:32] == 3'b101);
      check("head", {af_cmd, af_addr}, sb_q[0]);
      check("cmd_illegal", af_cmd_illegal, !legal);
    end else begin
      check("cmd_illegal_empty", af_cmd_illegal, 1'b0);
    end
    if (was_reset) check("reset_head", {af_cmd, af_addr}, 35'h0);
  endtask

  // One clock: apply inputs, advance the model, then compare after the edge.
  task automatic cyc(input bit rst, input bit we, input logic [35:0] d, input bit re);
    bit pop_acc, push_acc;
    reset        = rst;
    app_af_wren  = we;
    app_af_addr  = d;
    ctrl_af_rden = re;
    if (rst) begin
      sb_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      pop_acc  = re && (sb_q.size() > 0);
      push_acc = we && ((sb_q.size() < DEPTH) || pop_acc);
      if (we && !push_acc) m_ovf = 1'b1;
      if (re && !pop_acc)  m_unf = 1'b1;
      if (push_acc) sb_q.push_back(d[34:0]);
    end
    @(posedge clk);
    #1;
    verify(rst);
  endtask

  function automatic logic [35:0] rand_word(input bit legal);
    logic [2:0] c;
    c = legal ? {2'b10, 1'($urandom_range(0, 1))} : 3'($urandom_range(0, 7));
    return {1'($urandom_range(0, 1)), c, 32'($urandom)};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pushes;
    int n;
    bit we, re;

    // Reset for three cycles, then a single write.
    repeat (3) cyc(1'b1, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b1, 36'h4_0000_0100, 1'b0);
    check("first_cmd", af_cmd, 3'b100);
    check("first_addr", af_addr, 32'h100);
    cyc(1'b0, 1'b0, '0, 1'b1);

    // Fill past full, then drain.
    cyc(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, 1'b1, rand_word(1'b1), 1'b0);
    check("overflow_sticky", af_overflow, 1'b1);
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b0, '0, 1'b1);

    // Simultaneous push and pop while full.
    cyc(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, rand_word(1'b1), 1'b0);
    cyc(1'b0, 1'b1, rand_word(1'b1), 1'b1);
    check("full_pushpop_ovf", af_overflow, 1'b0);
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b0, '0, 1'b1);

    // Empty corner cases.
    cyc(1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b1, rand_word(1'b1), 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1);

    // Wrap and stream with occupancy held in 1..15.
    cyc(1'b1, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b1, rand_word(1'b1), 1'b0);
    pushes = 1;
    while (pushes < 40) begin
      n  = sb_q.size();
      we = ($urandom_range(0, 3) != 0) && (n <= DEPTH - 2);
      re = ($urandom_range(0, 1) == 1) && (n >= 2);
      if (we) pushes++;
      cyc(1'b0, we, rand_word(1'b1), re);
    end
    while (sb_q.size() > 0) cyc(1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b1, rand_word(1'b1), 1'b0);
    cyc(1'b0, 1'b1, {1'b0, 3'b111, 32'($urandom)}, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b1);
    check("illegal_at_head", af_cmd_illegal, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1);

    // Reset in the middle of operation.
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, rand_word(1'b1), 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b1, rand_word(1'b1), 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b1);

    // Unrestricted random traffic, including illegal commands and error cases.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) cyc(1'b1, 1'b0, '0, 1'b0);
      cyc(1'b0, $urandom_range(0, 99) < 60, rand_word($urandom_range(0, 3) != 0),
          $urandom_range(0, 99) < 45);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
